alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Front-end stage for the 6-bit signed add/subtract unit.
- Collects operands A and B one after the other from a shared switch bus, each on a LOAD strobe, plus the add/subtract select, and drives them as registered values into the adder.
- One cycle later it captures the adder's result and overflow into a held result register, with zero and negative flags, for display and for the downstream flag logic.

Parameters:
- W, 6, operand/result width (two's complement).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- DIN  in  W  shared operand bus (switches).
- LOAD  in  1  load request, level or pulse; only rising edges are acted on.
- OP_SUB  in  1  0 = A+B, 1 = A−B; sampled with B.
- CLR  in  1  synchronous clear.
- A_OUT  out  W  registered operand A to adder.
- B_OUT  out  W  registered operand B to adder.
- SEL_OUT  out  1  registered add/sub select to adder.
- Y_IN  in  W  adder result (combinational from A_OUT/B_OUT/SEL_OUT).
- OF_IN  in  1  adder signed overflow.
- RESULT  out  W  captured result.
- FLAG_OF  out  1  captured overflow.
- FLAG_Z  out  1  RESULT == 0.
- FLAG_N  out  1  RESULT[W-1].
- DONE  out  1  one-cycle pulse when RESULT updates.
- BUSY  out  1  high in S_EXEC.
- STATE  out  2  current state encoding, for debug LEDs.

Behaviour:
- Reset (RST_N=0, async):
  - State S_WAIT_A.
  - A_OUT, B_OUT, SEL_OUT, RESULT, all flags, DONE all 0.
  - load_q is set to 1, so a LOAD held high through reset release does not trigger.
- Edge detect:
  - load_q <= LOAD every cycle.
  - load_evt = LOAD & ~load_q.
  - A LOAD held high for N cycles gives exactly one event.
- States: S_WAIT_A=0, S_WAIT_B=1, S_EXEC=2, S_SHOW=3.
  - S_WAIT_A: on load_evt, A_OUT<=DIN, go to S_WAIT_B.
  - S_WAIT_B: on load_evt, B_OUT<=DIN, SEL_OUT<=OP_SUB, go to S_EXEC.
  - S_EXEC:
    - Exactly one cycle; BUSY=1; load_evt ignored.
    - At its ending edge: RESULT<=Y_IN, FLAG_OF<=OF_IN, FLAG_Z<=(Y_IN==0), FLAG_N<=Y_IN[W-1], DONE<=1, go to S_SHOW.
  - S_SHOW:
    - RESULT and flags held.
    - On load_evt, A_OUT<=DIN, go to S_WAIT_B.
    - RESULT and flags stay unchanged until the next capture.
- DONE:
  - Registered; high only in the first cycle of S_SHOW.
  - Cleared on the next edge whatever the state.
- Latency: B-load edge k → capture at edge k+1 → RESULT/DONE visible in the cycle after edge k+1.
- A_OUT, B_OUT and SEL_OUT hold their values in all states until overwritten. The adder input is stable throughout S_EXEC.
- Arithmetic: no width extension here. FLAG_N is the sign bit of the wrapped result and is not corrected on overflow.
- CLR (synchronous):
  - Same effect as reset, except load_q keeps tracking LOAD.
  - CLR beats a simultaneous load_evt.
  - CLR in S_EXEC aborts the capture; no DONE is produced.
- Reset mid-operation: an immediate async return to the reset values, with no DONE.
- No other transitions; every unlisted case holds state.

Test Plan:
- Add without overflow: load 12 then 7, OP_SUB=0.
  - Required: A_OUT=12, B_OUT=7, SEL_OUT=0.
  - Two edges after B load: RESULT=19 (0x13), OF=0, Z=0, N=0, DONE high exactly one cycle.
- Add with overflow: load 20 then 15, OP_SUB=0.
  - Required: RESULT=0x23 (−29), FLAG_OF=1, FLAG_N=1.
- Subtract: 5−5 → RESULT=0, FLAG_Z=1, FLAG_OF=0. Then −32−1 (0x20, 0x01, OP_SUB=1) → RESULT=0x1F, FLAG_OF=1, FLAG_N=0.
- Held LOAD:
  - LOAD high for 5 cycles in S_WAIT_A → only A latched, state S_WAIT_B.
  - LOAD asserted during S_EXEC → ignored.
  - LOAD high through reset release → no load.
- Chaining: from S_SHOW, load a new A → previous RESULT unchanged until the new capture, state goes directly to S_WAIT_B.
- Abort:
  - CLR coincident with a LOAD edge in S_WAIT_B → state S_WAIT_A, all outputs 0, no DONE.
  - RST_N pulsed low mid-cycle in S_EXEC → outputs 0 immediately, asynchronously, before the next clock edge.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bundle between the switch front-end, the sequencer and the 6-bit add/sub unit.
interface alu_operand_sequencer_if #(parameter int W = 6);
  logic [W-1:0] DIN;
  logic         LOAD;
  logic         OP_SUB;
  logic         CLR;
  logic [W-1:0] A_OUT;
  logic [W-1:0] B_OUT;
  logic         SEL_OUT;
  logic [W-1:0] Y_IN;
  logic         OF_IN;
  logic [W-1:0] RESULT;
  logic         FLAG_OF;
  logic         FLAG_Z;
  logic         FLAG_N;
  logic         DONE;
  logic         BUSY;
  logic [1:0]   STATE;

  modport slave (
    input  DIN, LOAD, OP_SUB, CLR, Y_IN, OF_IN,
    output A_OUT, B_OUT, SEL_OUT, RESULT, FLAG_OF, FLAG_Z, FLAG_N, DONE, BUSY, STATE
  );

  modport master (
    output DIN, LOAD, OP_SUB, CLR, Y_IN, OF_IN,
    input  A_OUT, B_OUT, SEL_OUT, RESULT, FLAG_OF, FLAG_Z, FLAG_N, DONE, BUSY, STATE
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A then B from the shared switch bus on LOAD rising edges, drives the adder,
// and captures the adder result and flags one cycle later.
module alu_operand_sequencer #(
  parameter int W = 6
) (
  input logic                  CLK,
  input logic                  RST_N,
  alu_operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT_A = 2'd0,
    S_WAIT_B = 2'd1,
    S_EXEC   = 2'd2,
    S_SHOW   = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           load_q;
  logic           load_evt;
  logic           load_a;
  logic           load_b;
  logic           capture;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           sel_reg;
  logic [W-1:0]   result_reg;
  logic           flag_of_reg;
  logic           flag_z_reg;
  logic           flag_n_reg;
  logic           done_reg;

  // load_q resets high so a LOAD held through reset release is not seen as an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) load_q <= 1'b1;
    else        load_q <= bus.LOAD;
  end

  assign load_evt = bus.LOAD & ~load_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_WAIT_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.CLR) begin
      state_nxt = S_WAIT_A;
    end else begin
      case (state)
        S_WAIT_A: if (load_evt) state_nxt = S_WAIT_B;
        S_WAIT_B: if (load_evt) state_nxt = S_EXEC;
        S_EXEC:   state_nxt = S_SHOW;
        S_SHOW:   if (load_evt) state_nxt = S_WAIT_B;
        default:  state_nxt = S_WAIT_A;
      endcase
    end
  end

  // CLR outranks every datapath enable, including the capture at the end of S_EXEC.
  always_comb begin
    load_a  = 1'b0;
    load_b  = 1'b0;
    capture = 1'b0;
    if (!bus.CLR) begin
      case (state)
        S_WAIT_A: load_a  = load_evt;
        S_WAIT_B: load_b  = load_evt;
        S_EXEC:   capture = 1'b1;
        S_SHOW:   load_a  = load_evt;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sel_reg     <= 1'b0;
      result_reg  <= '0;
      flag_of_reg <= 1'b0;
      flag_z_reg  <= 1'b0;
      flag_n_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else if (bus.CLR) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sel_reg     <= 1'b0;
      result_reg  <= '0;
      flag_of_reg <= 1'b0;
      flag_z_reg  <= 1'b0;
      flag_n_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= capture;
      if (load_a) a_reg <= bus.DIN;
      if (load_b) begin
        b_reg   <= bus.DIN;
        sel_reg <= bus.OP_SUB;
      end
      if (capture) begin
        result_reg  <= bus.Y_IN;
        flag_of_reg <= bus.OF_IN;
        flag_z_reg  <= (bus.Y_IN == '0);
        flag_n_reg  <= bus.Y_IN[W-1];
      end
    end
  end

  assign bus.A_OUT   = a_reg;
  assign bus.B_OUT   = b_reg;
  assign bus.SEL_OUT = sel_reg;
  assign bus.RESULT  = result_reg;
  assign bus.FLAG_OF = flag_of_reg;
  assign bus.FLAG_Z  = flag_z_reg;
  assign bus.FLAG_N  = flag_n_reg;
  assign bus.DONE    = done_reg;
  assign bus.BUSY    = (state == S_EXEC);
  assign bus.STATE   = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: vector table for add/sub results plus
// hand sequences for held LOAD, chaining, CLR and async reset aborts.
module tb_alu_operand_sequencer;

  localparam int W = 6;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  alu_operand_sequencer_if #(.W(W)) bus ();

  alu_operand_sequencer #(.W(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // Stand-in for the external 6-bit signed add/sub unit.
  logic signed [W:0] wide;
  always_comb begin
    wide = bus.SEL_OUT ? ($signed({bus.A_OUT[W-1], bus.A_OUT}) - $signed({bus.B_OUT[W-1], bus.B_OUT}))
                       : ($signed({bus.A_OUT[W-1], bus.A_OUT}) + $signed({bus.B_OUT[W-1], bus.B_OUT}));
  end
  assign bus.Y_IN  = wide[W-1:0];
  assign bus.OF_IN = wide[W] ^ wide[W-1];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         of;
    logic         z;
    logic         n;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle LOAD pulse: the rising edge is seen at the next clock edge.
  task automatic applyStimulus(input logic [W-1:0] din, input logic sub);
    bus.DIN    = din;
    bus.OP_SUB = sub;
    bus.LOAD   = 1'b1;
    tick();
    bus.LOAD   = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " STATE"},   32'(bus.STATE),   32'd0);
    checkOutput({tag, " A_OUT"},   32'(bus.A_OUT),   32'd0);
    checkOutput({tag, " B_OUT"},   32'(bus.B_OUT),   32'd0);
    checkOutput({tag, " SEL_OUT"}, 32'(bus.SEL_OUT), 32'd0);
    checkOutput({tag, " RESULT"},  32'(bus.RESULT),  32'd0);
    checkOutput({tag, " FLAGS"},   32'({bus.FLAG_OF, bus.FLAG_Z, bus.FLAG_N}), 32'd0);
    checkOutput({tag, " DONE"},    32'(bus.DONE),    32'd0);
    checkOutput({tag, " BUSY"},    32'(bus.BUSY),    32'd0);
  endtask

  logic [W-1:0] prev_result;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{a: 6'd12,  b: 6'd7,   sub: 1'b0, res: 6'h13, of: 1'b0, z: 1'b0, n: 1'b0};
    vecs[1] = '{a: 6'd20,  b: 6'd15,  sub: 1'b0, res: 6'h23, of: 1'b1, z: 1'b0, n: 1'b1};
    vecs[2] = '{a: 6'd5,   b: 6'd5,   sub: 1'b1, res: 6'h00, of: 1'b0, z: 1'b1, n: 1'b0};
    vecs[3] = '{a: 6'h20,  b: 6'h01,  sub: 1'b1, res: 6'h1F, of: 1'b1, z: 1'b0, n: 1'b0};
    vecs[4] = '{a: 6'h3F,  b: 6'h01,  sub: 1'b0, res: 6'h00, of: 1'b0, z: 1'b1, n: 1'b0};
    vecs[5] = '{a: 6'h10,  b: 6'h30,  sub: 1'b1, res: 6'h20, of: 1'b1, z: 1'b0, n: 1'b1};
    vecs[6] = '{a: 6'd3,   b: 6'd9,   sub: 1'b1, res: 6'h3A, of: 1'b0, z: 1'b0, n: 1'b1};

    // Reset with LOAD already high; release must not produce a load.
    bus.DIN = 6'h2A; bus.OP_SUB = 1'b0; bus.CLR = 1'b0; bus.LOAD = 1'b1;
    RST_N = 1'b0;
    tick(); tick();
    checkCleared("reset");
    RST_N = 1'b1;
    tick(); tick(); tick();
    checkOutput("held LOAD thru reset STATE", 32'(bus.STATE), 32'd0);
    checkOutput("held LOAD thru reset A_OUT", 32'(bus.A_OUT), 32'd0);
    bus.LOAD = 1'b0;
    tick();

    prev_result = '0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, 1'b0);
      checkOutput($sformatf("v%0d STATE after A", i), 32'(bus.STATE), 32'd1);
      checkOutput($sformatf("v%0d A_OUT", i), 32'(bus.A_OUT), 32'(vecs[i].a));
      checkOutput($sformatf("v%0d RESULT held after A", i), 32'(bus.RESULT), 32'(prev_result));
      tick();
      applyStimulus(vecs[i].b, vecs[i].sub);
      checkOutput($sformatf("v%0d STATE exec", i), 32'(bus.STATE), 32'd2);
      checkOutput($sformatf("v%0d BUSY", i), 32'(bus.BUSY), 32'd1);
      checkOutput($sformatf("v%0d B_OUT", i), 32'(bus.B_OUT), 32'(vecs[i].b));
      checkOutput($sformatf("v%0d SEL_OUT", i), 32'(bus.SEL_OUT), 32'(vecs[i].sub));
      checkOutput($sformatf("v%0d DONE early", i), 32'(bus.DONE), 32'd0);
      checkOutput($sformatf("v%0d RESULT before capture", i), 32'(bus.RESULT), 32'(prev_result));
      tick();
      checkOutput($sformatf("v%0d STATE show", i), 32'(bus.STATE), 32'd3);
      checkOutput($sformatf("v%0d DONE", i), 32'(bus.DONE), 32'd1);
      checkOutput($sformatf("v%0d BUSY off", i), 32'(bus.BUSY), 32'd0);
      checkOutput($sformatf("v%0d RESULT", i), 32'(bus.RESULT), 32'(vecs[i].res));
      checkOutput($sformatf("v%0d OF/Z/N", i), 32'({bus.FLAG_OF, bus.FLAG_Z, bus.FLAG_N}),
                  32'({vecs[i].of, vecs[i].z, vecs[i].n}));
      tick();
      checkOutput($sformatf("v%0d DONE one cycle", i), 32'(bus.DONE), 32'd0);
      checkOutput($sformatf("v%0d RESULT held", i), 32'(bus.RESULT), 32'(vecs[i].res));
      prev_result = vecs[i].res;
    end

    // LOAD held for 5 cycles from S_SHOW latches A once; DIN changes are ignored meanwhile.
    bus.DIN = 6'd9; bus.LOAD = 1'b1;
    tick();
    bus.DIN = 6'd33;
    tick(); tick(); tick(); tick();
    checkOutput("held LOAD STATE", 32'(bus.STATE), 32'd1);
    checkOutput("held LOAD A_OUT", 32'(bus.A_OUT), 32'd9);
    checkOutput("held LOAD B_OUT untouched", 32'(bus.B_OUT), 32'(vecs[6].b));
    bus.LOAD = 1'b0;
    tick();
    // LOAD stays high through S_EXEC: no new A, capture still happens.
    bus.DIN = 6'd4; bus.OP_SUB = 1'b0; bus.LOAD = 1'b1;
    tick();
    bus.DIN = 6'd21;
    checkOutput("exec w/ LOAD STATE", 32'(bus.STATE), 32'd2);
    tick();
    checkOutput("exec w/ LOAD A_OUT", 32'(bus.A_OUT), 32'd9);
    checkOutput("exec w/ LOAD STATE show", 32'(bus.STATE), 32'd3);
    checkOutput("exec w/ LOAD RESULT", 32'(bus.RESULT), 32'd13);
    checkOutput("exec w/ LOAD DONE", 32'(bus.DONE), 32'd1);
    tick();
    checkOutput("exec w/ LOAD still show", 32'(bus.STATE), 32'd3);
    bus.LOAD = 1'b0;
    tick();

    // CLR together with a B-load edge in S_WAIT_B.
    applyStimulus(6'd17, 1'b0);
    tick();
    bus.CLR = 1'b1; bus.DIN = 6'd5; bus.OP_SUB = 1'b1; bus.LOAD = 1'b1;
    tick();
    bus.CLR = 1'b0; bus.LOAD = 1'b0;
    checkCleared("CLR in WAIT_B");
    tick();
    checkOutput("CLR in WAIT_B no DONE", 32'(bus.DONE), 32'd0);
    checkOutput("CLR in WAIT_B STATE", 32'(bus.STATE), 32'd0);

    // CLR on the S_EXEC ending edge aborts the capture.
    applyStimulus(6'd2, 1'b0);
    tick();
    applyStimulus(6'd3, 1'b0);
    checkOutput("CLR exec BUSY", 32'(bus.BUSY), 32'd1);
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    checkCleared("CLR in EXEC");
    tick();
    checkOutput("CLR in EXEC no late DONE", 32'(bus.DONE), 32'd0);

    // Build a nonzero RESULT, then pulse RST_N low in the middle of S_EXEC.
    applyStimulus(6'd1, 1'b0);
    tick();
    applyStimulus(6'd6, 1'b0);
    tick();
    checkOutput("pre-reset RESULT", 32'(bus.RESULT), 32'd7);
    tick();
    applyStimulus(6'd8, 1'b0);
    tick();
    applyStimulus(6'd2, 1'b1);
    checkOutput("pre-reset exec STATE", 32'(bus.STATE), 32'd2);
    #2;
    RST_N = 1'b0;
    #1;
    checkCleared("async reset in EXEC");
    #1;
    RST_N = 1'b1;
    tick();
    checkOutput("after async reset DONE", 32'(bus.DONE), 32'd0);
    checkOutput("after async reset STATE", 32'(bus.STATE), 32'd0);
    checkOutput("after async reset RESULT", 32'(bus.RESULT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
